// File: rtl/alu_pkg.sv
// Shared ALUControl encodings and execute-stage FSM state type for the ALU decoder and alu_seq.
package alu_pkg;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SRA = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/alu_sra_step.sv
// Combinational arithmetic right shift of a WIDTH value by shamt (sign bit replicated).
module alu_sra_step #(
    parameter int WIDTH = 32,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] value,
    input  logic [SW-1:0]    shamt,
    output logic [WIDTH-1:0] shifted
);
    assign shifted = WIDTH'($signed(value) >>> shamt);
endmodule

// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU execute stage: single-step add/sub/and/or/slt, iterative sra.
// Define ALU_SEQ_BARREL_EN to make sra single-step through a full barrel shifter.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);
    localparam int SW = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] step_res;
    logic             step_ill;

    assign shamt     = b[SW-1:0];
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

`ifdef ALU_SEQ_BARREL_EN
    alu_sra_step #(.WIDTH(WIDTH), .SW(SW)) u_sra (
        .value   (a),
        .shamt   (shamt),
        .shifted (shifted)
    );
`else
    logic [SW-1:0] count;

    // One bit per cycle; the result register doubles as the shift register.
    alu_sra_step #(.WIDTH(WIDTH), .SW(SW)) u_sra (
        .value   (result),
        .shamt   (SW'(1)),
        .shifted (shifted)
    );
`endif

    always_comb begin
        step_res = '0;
        step_ill = 1'b0;
        unique case (alu_control)
            ALU_ADD: step_res = a + b;
            ALU_SUB: step_res = a - b;
            ALU_AND: step_res = a & b;
            ALU_OR:  step_res = a | b;
            ALU_SLT: step_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_SEQ_BARREL_EN
            ALU_SRA: step_res = shifted;
`else
            ALU_SRA: step_res = a;
`endif
            default: step_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (in_valid) begin
`ifdef ALU_SEQ_BARREL_EN
                    state_nxt = S_DONE;
`else
                    state_nxt = (alu_control == ALU_SRA && shamt != '0) ? S_SHIFT : S_DONE;
`endif
                end
            end
`ifndef ALU_SEQ_BARREL_EN
            S_SHIFT: if (count == SW'(1)) state_nxt = S_DONE;
`endif
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
`ifndef ALU_SEQ_BARREL_EN
            count   <= '0;
`endif
        end else if (state == S_IDLE && in_valid) begin
            result  <= step_res;
            zero    <= (step_res == '0);
            illegal <= step_ill;
`ifndef ALU_SEQ_BARREL_EN
            count   <= shamt;
`endif
        end
`ifndef ALU_SEQ_BARREL_EN
        else if (state == S_SHIFT) begin
            result <= shifted;
            count  <= count - SW'(1);
            // zero tracks only the final shifted value
            if (count == SW'(1)) zero <= (shifted == '0);
        end
`endif
    end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: latency/result model plus directed literal cases and random ops.
module tb_alu_seq;
    logic        clk, reset_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  alu_control;
    logic [31:0] a, b, result;
    logic        zero, illegal;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: value, illegal flag and number of extra edges before out_valid.
    function automatic void ref_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] r, output bit ill, output int d);
        int sh;
        sh  = int'(y[4:0]);
        r   = 32'h0;
        ill = 1'b0;
        d   = 0;
        case (op)
            3'b000: r = x + y;
            3'b001: r = x - y;
            3'b010: r = x & y;
            3'b011: r = x | y;
            3'b101: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'b111: begin
                r = (x >> sh) | (x[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
`ifndef ALU_SEQ_BARREL_EN
                d = sh;
`endif
            end
            default: ill = 1'b1;
        endcase
    endfunction

    function automatic int lit_lat(input int k);
`ifdef ALU_SEQ_BARREL_EN
        return 1 + 0 * k;
`else
        return k + 1;
`endif
    endfunction

    // Behavioural model: busy flag, edges since acceptance, expected outcome.
    bit          m_busy  = 1'b0;
    bit          m_fresh = 1'b1;
    int          m_cyc   = 0;
    int          m_d     = 0;
    logic [31:0] m_res   = 32'h0;
    bit          m_ill   = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy  = 1'b0;
            m_fresh = 1'b1;
            m_cyc   = 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                ref_op(alu_control, a, b, m_res, m_ill, m_d);
                m_busy  = 1'b1;
                m_fresh = 1'b0;
                m_cyc   = 0;
            end
        end else if (m_cyc >= m_d && out_ready) begin
            m_busy = 1'b0;
        end else if (m_cyc < 1000) begin
            m_cyc++;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_result", result, 32'h0);
            chk("rst_zero", 32'(zero), 32'd0);
            chk("rst_illegal", 32'(illegal), 32'd0);
        end else begin
            chk("in_ready", 32'(in_ready), 32'(!m_busy));
            chk("out_valid", 32'(out_valid), 32'(m_busy && m_cyc >= m_d));
            if (m_busy && m_cyc >= m_d) begin
                chk("result", result, m_res);
                chk("zero", 32'(zero), 32'(m_res == 32'h0));
                chk("illegal", 32'(illegal), 32'(m_ill));
            end
            if (m_fresh) begin
                chk("idle_result", result, 32'h0);
                chk("idle_flags", {30'h0, zero, illegal}, 32'h0);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input bit keep, input logic [2:0] nop, input logic [31:0] na, input logic [31:0] nb);
        int n;
        alu_control = op;
        a           = av;
        b           = bv;
        in_valid    = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            $display("FAIL accept_timeout: in_ready stuck at %0d", in_ready);
            errors++;
            checks++;
        end
        @(posedge clk);
        @(negedge clk);
        if (keep) begin
            alu_control = nop;
            a           = na;
            b           = nb;
        end else begin
            in_valid = 1'b0;
            a        = $urandom;
            b        = $urandom;
        end
    endtask

    task automatic collect(input int hold, input bit lit, input logic [31:0] er,
                           input logic ez, input logic ei, input int el);
        int n;
        n = 1;
        while (!out_valid && n < 100) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        out_ready = 1'b0;
        if (!out_valid) begin
            $display("FAIL result_timeout: out_valid %0d after %0d cycles", out_valid, n);
            errors++;
            checks++;
        end
        if (lit) begin
            chk("lit_result", result, er);
            chk("lit_zero", 32'(zero), 32'(ez));
            chk("lit_illegal", 32'(illegal), 32'(ei));
            chk("lit_latency", 32'(n), 32'(el));
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (lit) chk("hold_result", result, er);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic op_lit(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] er, input logic ez, input logic ei, input int el);
        issue(op, av, bv, 1'b0, 3'b0, 32'h0, 32'h0);
        collect(0, 1'b1, er, ez, ei, el);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time %0t exceeded limit %0d", $time, 2000000);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        alu_control = 3'b000;
        a           = 32'h0;
        b           = 32'h0;
        #1 reset_n  = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        op_lit(3'b000, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1);
        op_lit(3'b001, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
        op_lit(3'b101, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1);
        op_lit(3'b101, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1);
        op_lit(3'b111, 32'h8000_00F0, 32'd4, 32'hF800_000F, 1'b0, 1'b0, lit_lat(4));
        op_lit(3'b111, 32'h8000_00F0, 32'd0, 32'h8000_00F0, 1'b0, 1'b0, 1);
        op_lit(3'b111, 32'h8000_00F0, 32'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, lit_lat(31));
        op_lit(3'b110, 32'h1234_5678, 32'h9, 32'h0, 1'b1, 1'b1, 1);
        op_lit(3'b010, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 1);
        op_lit(3'b100, 32'h5, 32'h6, 32'h0, 1'b1, 1'b1, 1);
        op_lit(3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1);

        // Backpressure with a second op offered throughout the stall.
        issue(3'b011, 32'h1234, 32'h5678, 1'b1, 3'b000, 32'd5, 32'd6);
        collect(10, 1'b1, 32'h567C, 1'b0, 1'b0, 1);
        issue(3'b000, 32'd5, 32'd6, 1'b0, 3'b0, 32'h0, 32'h0);
        collect(0, 1'b1, 32'd11, 1'b0, 1'b0, 1);

        // Reset in the middle of a 16-step shift.
        issue(3'b111, 32'h8000_0000, 32'd16, 1'b0, 3'b0, 32'h0, 32'h0);
        repeat (4) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_result", result, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        op_lit(3'b001, 32'd100, 32'd58, 32'd42, 1'b0, 1'b0, 1);

        for (int i = 0; i < 80; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            issue(op, rnd_val(), rnd_val(), 1'b0, 3'b0, 32'h0, 32'h0);
            collect($urandom_range(0, 3), 1'b0, 32'h0, 1'b0, 1'b0, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
